decode_execute_register: RTL and testbench
==========================================

Name: decode_execute_register

Overview:
- Pipeline register between the decode stage (main decoder, ALU decoder, register file, immediate extender) and the execute stage of the 5-stage RV32I core.
- Captures the decoder control bundle and the decoded datapath fields on each clock.
- Supports stall (hold) and flush (bubble insertion), and tracks slot validity.
- Keeps a saturating count of bubbles inserted, for performance debug.

Parameters:
- XLEN, 32, datapath width (operands, PC, immediate).
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, bubble counter width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- StallE  input  1  hold all E-stage contents.
- FlushE  input  1  load a bubble (branch/jump redirect or load-use).
- ValidD  input  1  the D-stage slot holds a real instruction.
- RegWriteD  input  1  decoder control.
- ResultSrcD  input  2  00 ALU, 01 memory, 10 PC+4.
- MemWriteD  input  1  decoder control.
- JumpD  input  1  decoder control.
- BranchD  input  1  decoder control.
- ALUSrcD  input  1  decoder control.
- ALUControlD  input  3  from the ALU decoder.
- RD1D, RD2D  input  XLEN  register file read data.
- PCD, PCPlus4D  input  XLEN  instruction PC and PC+4.
- ImmExtD  input  XLEN  extended immediate.
- Rs1D, Rs2D, RdD  input  REG_ADDR_W  register indices.
- Outputs: the same names with suffix E (RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE), each  output  with the same width as its D input.
- ValidE  output  1  the E slot is real.
- BubbleCountE  output  CNT_W  saturating bubble counter.

Behaviour:
- Reset (rst=1, asynchronous): every output is 0, including ValidE and BubbleCountE. A reset during a stall or flush wins immediately. Release is synchronous to the next edge.
- Update priority at a rising edge: rst > FlushE > StallE > load.
- Flush:
  - All control outputs become 0.
  - Rs1E, Rs2E and RdE become 0, so forwarding and hazard logic never match a bubble.
  - Data fields (RD1E, RD2E, PCE, PCPlus4E, ImmExtE) become 0.
  - ValidE becomes 0.
- FlushE and StallE both high: flush wins and a bubble is loaded.
- Stall (FlushE=0, StallE=1): every output holds its value, BubbleCountE included.
- Load (FlushE=0, StallE=0):
  - All E fields take their D values one cycle later. Latency is exactly 1 cycle.
  - ValidE takes ValidD.
  - If ValidD=0, then RegWriteE, MemWriteE, JumpE and BranchE are forced to 0. Other fields load normally.
- Bubble counter: increments by 1 on every non-reset edge where ValidE is written 0, i.e. a flush, or a load with ValidD=0. It saturates at 2^CNT_W-1 and does not wrap.
- No combinational path from any input to any output.

Decomposition:
- Shared package riscv_pkg:
  - Opcode constants: OP_LOAD 0000011, OP_STORE 0100011, OP_RTYPE 0110011, OP_ITYPE 0010011, OP_BRANCH 1100011, OP_JAL 1101111, OP_LUI 0110111.
  - ResultSrc encodings: RES_ALU, RES_MEM, RES_PC4.
  - ImmSrc encodings: I 000, S 001, B 010, J 011, U 100.
  - ALUOp encodings: 00 add, 01 branch, 10 funct-decoded, 11 LUI.
  - A packed control-bundle typedef (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ALUControl).
- One natural sub-module: pipe_field_reg. It is a parameterised-width register with async reset, synchronous clear and enable. It is instantiated once for the control bundle and once for the data bundle. The bubble counter stays in the top level.

Test Plan:
- Reset mid-load: drive RegWriteD=1, RdD=5, ValidD=1, then assert rst asynchronously between edges -> all outputs 0 immediately, BubbleCountE=0.
- Plain load: ValidD=1, RegWriteD=1, ResultSrcD=01, RD1D=0x0000_1234, RdD=7 -> one edge later RegWriteE=1, ResultSrcE=01, RD1E=0x1234, RdE=7, ValidE=1; BubbleCountE unchanged.
- Stall: load a store (MemWriteD=1, PCD=0x40), then StallE=1 for 3 cycles while D inputs change to PCD=0x44 -> PCE stays 0x40 and MemWriteE stays 1 for 3 cycles; after release PCE=0x44 one edge later.
- Flush over stall: FlushE=1 and StallE=1 with JumpD=1, RdD=1 -> JumpE=0, RdE=0, ValidE=0, BubbleCountE incremented by 1.
- Invalid slot: ValidD=0, RegWriteD=1, MemWriteD=1, BranchD=1, RdD=3 -> RegWriteE=0, MemWriteE=0, BranchE=0, RdE=3, ValidE=0, counter +1.
- Counter saturation: with CNT_W=4, hold FlushE=1 for 20 edges -> BubbleCountE reaches 15 and stays at 15.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: opcodes, control encodings and the decoder control bundle.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_LUI    = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_control;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/decode_execute_register_if.sv
// Decode-to-execute boundary signals; the register is the slave, the decode side the master.
interface decode_execute_register_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                  StallE, FlushE, ValidD;
  logic                  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]            ResultSrcD;
  logic [2:0]            ALUControlD;
  logic [XLEN-1:0]       RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [REG_ADDR_W-1:0] Rs1D, Rs2D, RdD;

  logic                  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
  logic [1:0]            ResultSrcE;
  logic [2:0]            ALUControlE;
  logic [XLEN-1:0]       RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [REG_ADDR_W-1:0] Rs1E, Rs2E, RdE;
  logic [CNT_W-1:0]      BubbleCountE;

  modport master (
    output StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ResultSrcD, ALUControlD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, ResultSrcE, ALUControlE,
           RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, BubbleCountE
  );

  modport slave (
    input  StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ResultSrcD, ALUControlD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, ResultSrcE, ALUControlE,
           RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, BubbleCountE
  );
endinterface

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async reset, synchronous clear over enable.
module pipe_field_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/decode_execute_register.sv
// D/E pipeline register: control and data bundles with stall, flush, slot validity
// and a saturating count of bubbles entering the execute stage.
module decode_execute_register
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input logic                      clk,
  input logic                      rst,
  decode_execute_register_if.slave bus
);

  localparam int unsigned DATA_W = 5 * XLEN + 3 * REG_ADDR_W;

  ctrl_t             ctrl_d, ctrl_q;
  logic              valid_q;
  logic [CTRL_W:0]   ctrl_vq;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CNT_W-1:0]  bubble_cnt;
  logic              bubble_c;

  // An invalid slot must never commit architectural side effects.
  always_comb begin
    ctrl_d             = '0;
    ctrl_d.reg_write   = bus.RegWriteD & bus.ValidD;
    ctrl_d.result_src  = bus.ResultSrcD;
    ctrl_d.mem_write   = bus.MemWriteD & bus.ValidD;
    ctrl_d.jump        = bus.JumpD & bus.ValidD;
    ctrl_d.branch      = bus.BranchD & bus.ValidD;
    ctrl_d.alu_src     = bus.ALUSrcD;
    ctrl_d.alu_control = bus.ALUControlD;
  end

  assign data_d = {bus.RD1D, bus.RD2D, bus.PCD, bus.PCPlus4D, bus.ImmExtD,
                   bus.Rs1D, bus.Rs2D, bus.RdD};

  pipe_field_reg #(.W(CTRL_W + 1)) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .en  (~bus.StallE),
    .clr (bus.FlushE),
    .d   ({ctrl_d, bus.ValidD}),
    .q   (ctrl_vq)
  );

  pipe_field_reg #(.W(DATA_W)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (~bus.StallE),
    .clr (bus.FlushE),
    .d   (data_d),
    .q   (data_q)
  );

  assign {ctrl_q, valid_q} = ctrl_vq;

  assign bus.RegWriteE   = ctrl_q.reg_write;
  assign bus.ResultSrcE  = ctrl_q.result_src;
  assign bus.MemWriteE   = ctrl_q.mem_write;
  assign bus.JumpE       = ctrl_q.jump;
  assign bus.BranchE     = ctrl_q.branch;
  assign bus.ALUSrcE     = ctrl_q.alu_src;
  assign bus.ALUControlE = ctrl_q.alu_control;
  assign bus.ValidE      = valid_q;

  assign {bus.RD1E, bus.RD2E, bus.PCE, bus.PCPlus4E, bus.ImmExtE,
          bus.Rs1E, bus.Rs2E, bus.RdE} = data_q;

  // A bubble is any edge that writes ValidE low.
  assign bubble_c = bus.FlushE | (~bus.StallE & ~bus.ValidD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubble_cnt <= '0;
    else if (bubble_c && (bubble_cnt != {CNT_W{1'b1}}))
      bubble_cnt <= bubble_cnt + CNT_W'(1);
  end

  assign bus.BubbleCountE = bubble_cnt;

endmodule

// File: tb/tb_decode_execute_register.sv
// Randomized bench for the D/E register against a behavioural model; a second
// instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_decode_execute_register;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_execute_register_if #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(16)) bus16 ();
  decode_execute_register_if #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4))  bus4 ();

  decode_execute_register #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16.slave));
  decode_execute_register #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));

  typedef struct {
    logic stall, flush, valid;
    logic rw, mw, j, b, as;
    logic [1:0] rs;
    logic [2:0] ac;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0] rs1, rs2, rd;
  } in_t;

  typedef struct {
    logic rw, mw, j, b, as, v;
    logic [1:0] rs;
    logic [2:0] ac;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0] rs1, rs2, rd;
    int cnt16, cnt4;
  } model_t;

  in_t    din;
  model_t m;
  int     vectors = 0;
  int     miscompares = 0;

  assign bus4.StallE = bus16.StallE;       assign bus4.FlushE = bus16.FlushE;
  assign bus4.ValidD = bus16.ValidD;       assign bus4.RegWriteD = bus16.RegWriteD;
  assign bus4.MemWriteD = bus16.MemWriteD; assign bus4.JumpD = bus16.JumpD;
  assign bus4.BranchD = bus16.BranchD;     assign bus4.ALUSrcD = bus16.ALUSrcD;
  assign bus4.ResultSrcD = bus16.ResultSrcD; assign bus4.ALUControlD = bus16.ALUControlD;
  assign bus4.RD1D = bus16.RD1D;           assign bus4.RD2D = bus16.RD2D;
  assign bus4.PCD = bus16.PCD;             assign bus4.PCPlus4D = bus16.PCPlus4D;
  assign bus4.ImmExtD = bus16.ImmExtD;     assign bus4.Rs1D = bus16.Rs1D;
  assign bus4.Rs2D = bus16.Rs2D;           assign bus4.RdD = bus16.RdD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic drive();
    bus16.StallE = din.stall;   bus16.FlushE = din.flush;   bus16.ValidD = din.valid;
    bus16.RegWriteD = din.rw;   bus16.MemWriteD = din.mw;   bus16.JumpD = din.j;
    bus16.BranchD = din.b;      bus16.ALUSrcD = din.as;     bus16.ResultSrcD = din.rs;
    bus16.ALUControlD = din.ac; bus16.RD1D = din.rd1;       bus16.RD2D = din.rd2;
    bus16.PCD = din.pc;         bus16.PCPlus4D = din.pc4;   bus16.ImmExtD = din.imm;
    bus16.Rs1D = din.rs1;       bus16.Rs2D = din.rs2;       bus16.RdD = din.rd;
  endtask

  task automatic model_reset();
    m = '{default: 0};
  endtask

  function automatic int sat_inc(input int c, input int max);
    return (c < max) ? c + 1 : max;
  endfunction

  // Next E contents from the rules: flush clears, stall holds, load copies with masking.
  task automatic model_edge();
    if (din.flush) begin
      int c16 = m.cnt16, c4 = m.cnt4;
      m = '{default: 0};
      m.cnt16 = sat_inc(c16, 65535);
      m.cnt4  = sat_inc(c4, 15);
    end else if (!din.stall) begin
      m.v = din.valid;
      m.rw = din.rw & din.valid; m.mw = din.mw & din.valid;
      m.j  = din.j & din.valid;  m.b  = din.b & din.valid;
      m.as = din.as; m.rs = din.rs; m.ac = din.ac;
      m.rd1 = din.rd1; m.rd2 = din.rd2; m.pc = din.pc; m.pc4 = din.pc4; m.imm = din.imm;
      m.rs1 = din.rs1; m.rs2 = din.rs2; m.rd = din.rd;
      if (!din.valid) begin
        m.cnt16 = sat_inc(m.cnt16, 65535);
        m.cnt4  = sat_inc(m.cnt4, 15);
      end
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".RegWriteE"},   32'(bus16.RegWriteE),   32'(m.rw));
    check({ph, ".ResultSrcE"},  32'(bus16.ResultSrcE),  32'(m.rs));
    check({ph, ".MemWriteE"},   32'(bus16.MemWriteE),   32'(m.mw));
    check({ph, ".JumpE"},       32'(bus16.JumpE),       32'(m.j));
    check({ph, ".BranchE"},     32'(bus16.BranchE),     32'(m.b));
    check({ph, ".ALUSrcE"},     32'(bus16.ALUSrcE),     32'(m.as));
    check({ph, ".ALUControlE"}, 32'(bus16.ALUControlE), 32'(m.ac));
    check({ph, ".RD1E"},        bus16.RD1E,             m.rd1);
    check({ph, ".RD2E"},        bus16.RD2E,             m.rd2);
    check({ph, ".PCE"},         bus16.PCE,              m.pc);
    check({ph, ".PCPlus4E"},    bus16.PCPlus4E,         m.pc4);
    check({ph, ".ImmExtE"},     bus16.ImmExtE,          m.imm);
    check({ph, ".Rs1E"},        32'(bus16.Rs1E),        32'(m.rs1));
    check({ph, ".Rs2E"},        32'(bus16.Rs2E),        32'(m.rs2));
    check({ph, ".RdE"},         32'(bus16.RdE),         32'(m.rd));
    check({ph, ".ValidE"},      32'(bus16.ValidE),      32'(m.v));
    check({ph, ".BubbleCountE"},  32'(bus16.BubbleCountE), m.cnt16);
    check({ph, ".BubbleCount4E"}, 32'(bus4.BubbleCountE),  m.cnt4);
    check({ph, ".ValidE4"},     32'(bus4.ValidE),       32'(m.v));
  endtask

  task automatic step(input string ph);
    drive();
    model_edge();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic randomize_in(input int flush_pct, input int stall_pct);
    din.flush = ($urandom_range(0, 99) < flush_pct);
    din.stall = ($urandom_range(0, 99) < stall_pct);
    din.valid = ($urandom_range(0, 99) < 80);
    din.rw = 1'($urandom); din.mw = 1'($urandom); din.j = 1'($urandom);
    din.b  = 1'($urandom); din.as = 1'($urandom);
    din.rs = 2'($urandom_range(0, 2)); din.ac = 3'($urandom);
    din.rd1 = $urandom; din.rd2 = $urandom; din.pc = $urandom & 32'hFFFF_FFFC;
    din.pc4 = din.pc + 32'd4; din.imm = $urandom;
    din.rs1 = 5'($urandom); din.rs2 = 5'($urandom); din.rd = 5'($urandom);
  endtask

  initial begin
    din = '{default: 0};
    drive();
    rst = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load, then reset asynchronously between edges.
    din.valid = 1'b1; din.rw = 1'b1; din.rd = 5'd5;
    step("load_rd5");
    check("load_rd5.RdE", 32'(bus16.RdE), 32'd5);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst = 1'b0;

    // Plain load.
    din = '{default: 0};
    din.valid = 1'b1; din.rw = 1'b1; din.rs = 2'b01; din.rd1 = 32'h0000_1234; din.rd = 5'd7;
    step("plain_load");
    check("plain_load.RD1E", bus16.RD1E, 32'h0000_1234);
    check("plain_load.BubbleCountE", 32'(bus16.BubbleCountE), 32'd0);

    // Store held through a 3-cycle stall, then released.
    din = '{default: 0};
    din.valid = 1'b1; din.mw = 1'b1; din.pc = 32'h40;
    step("store");
    din.pc = 32'h44; din.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check("stall.PCE", bus16.PCE, 32'h40);
    end
    din.stall = 1'b0;
    step("release");
    check("release.PCE", bus16.PCE, 32'h44);

    // Flush and stall together: flush wins.
    din.flush = 1'b1; din.stall = 1'b1; din.j = 1'b1; din.rd = 5'd1;
    step("flush_stall");
    check("flush_stall.BubbleCountE", 32'(bus16.BubbleCountE), 32'd1);

    // Invalid slot masks side-effecting controls but keeps indices.
    din = '{default: 0};
    din.rw = 1'b1; din.mw = 1'b1; din.b = 1'b1; din.rd = 5'd3;
    step("invalid");
    check("invalid.RdE", 32'(bus16.RdE), 32'd3);
    check("invalid.BubbleCountE", 32'(bus16.BubbleCountE), 32'd2);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      randomize_in(15, 20);
      step("random");
    end

    // Saturation of the 4-bit counter from a clean reset.
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_all("reset2");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      randomize_in(100, 50);
      step("saturate");
    end
    check("saturate.BubbleCount4E", 32'(bus4.BubbleCountE), 32'd15);
    check("saturate.BubbleCountE", 32'(bus16.BubbleCountE), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
